// File: rtl/hazard_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath (master) and
// the hazard controller (slave): register addresses and enables in; stalls, flushes, forwarding selects and counters out.
interface hazard_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1AddrD;
  logic [4:0]       rs2AddrD;
  logic [4:0]       rs1AddrE;
  logic [4:0]       rs2AddrE;
  logic [4:0]       rdAddrE;
  logic [1:0]       ResultSrcE;
  logic [4:0]       rdAddrM;
  logic [4:0]       rdAddrW;
  logic             RegWriteM;
  logic             RegWriteW;
  logic             PCSrcE;
  logic             MemReqM;
  logic             MemReadyM;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             memError;
  logic [CNT_W-1:0] stallCycles;
  logic [CNT_W-1:0] flushCount;

  modport master (
    output rs1AddrD, rs2AddrD, rs1AddrE, rs2AddrE, rdAddrE, ResultSrcE,
           rdAddrM, rdAddrW, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE,
           ForwardAE, ForwardBE, memError, stallCycles, flushCount
  );

  modport slave (
    input  rs1AddrD, rs2AddrD, rs1AddrE, rs2AddrE, rdAddrE, ResultSrcE,
           rdAddrM, rdAddrW, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE,
           ForwardAE, ForwardBE, memError, stallCycles, flushCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage RISC-V pipeline: forwarding selects,
// load-use and memory-wait stalls, branch flushes, timeout FSM and perf counters.
module hazard_ctrl #(
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = 200,
  parameter int CNT_W       = 32
) (
  input logic     clk,
  input logic     reset,
  hazard_if.slave hz
);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERR} state_t;

  state_t           state, state_nxt;
  logic [TMO_W-1:0] tmo, tmo_nxt;
  logic             mem_error, mem_error_nxt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             lw_stall, mem_stall;
  logic             stall_f, flush_e;

  // Memory stage wins over Writeback; x0 is never a forwarding source.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       wen_m,
                                         input logic [4:0] rd_m,
                                         input logic       wen_w,
                                         input logic [4:0] rd_w);
    if (wen_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
    else if (wen_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    else                                          return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  // A taken branch squashes the Decode instruction, so it also cancels the load-use stall.
  assign lw_stall = (hz.ResultSrcE == 2'b01) && (hz.rdAddrE != 5'd0) &&
                    ((hz.rdAddrE == hz.rs1AddrD) || (hz.rdAddrE == hz.rs2AddrD)) &&
                    !hz.PCSrcE;

  assign mem_stall = ((state == S_RUN) && hz.MemReqM && !hz.MemReadyM) ||
                     (state == S_WAIT) || (state == S_ERR);

  always_comb begin
    stall_f      = 1'b0;
    flush_e      = 1'b1;
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.StallE    = 1'b0;
    hz.StallM    = 1'b0;
    hz.FlushD    = 1'b1;
    hz.FlushE    = 1'b1;
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    if (reset) begin
      stall_f      = mem_stall || lw_stall;
      flush_e      = (lw_stall || hz.PCSrcE) && !mem_stall;
      hz.StallF    = stall_f;
      hz.StallD    = stall_f;
      hz.StallE    = mem_stall;
      hz.StallM    = mem_stall;
      hz.FlushD    = hz.PCSrcE && !mem_stall;
      hz.FlushE    = flush_e;
      hz.ForwardAE = fwd_sel(hz.rs1AddrE, hz.RegWriteM, hz.rdAddrM, hz.RegWriteW, hz.rdAddrW);
      hz.ForwardBE = fwd_sel(hz.rs2AddrE, hz.RegWriteM, hz.rdAddrM, hz.RegWriteW, hz.rdAddrW);
    end
  end

  always_comb begin
    state_nxt     = state;
    tmo_nxt       = tmo;
    mem_error_nxt = mem_error;
    case (state)
      S_RUN: begin
        if (hz.MemReqM && !hz.MemReadyM) begin
          state_nxt = S_WAIT;
          tmo_nxt   = TMO_W'(1);
        end
      end
      S_WAIT: begin
        if (hz.MemReadyM) begin
          state_nxt = S_RUN;
          tmo_nxt   = '0;
        end else if (tmo == TMO_W'(MEM_TIMEOUT - 1)) begin
          state_nxt     = S_ERR;
          mem_error_nxt = 1'b1;
        end else begin
          tmo_nxt = tmo + TMO_W'(1);
        end
      end
      S_ERR: begin
        state_nxt     = S_ERR;
        mem_error_nxt = 1'b1;
      end
      default: begin
        state_nxt = S_RUN;
        tmo_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_RUN;
      tmo       <= '0;
      mem_error <= 1'b0;
    end else begin
      state     <= state_nxt;
      tmo       <= tmo_nxt;
      mem_error <= mem_error_nxt;
    end
  end

  // Counters freeze once the controller is stuck in the timeout state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f && state != S_ERR) stall_cnt <= sat_inc(stall_cnt);
      if (flush_e && hz.PCSrcE)      flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign hz.memError    = mem_error;
  assign hz.stallCycles = stall_cnt;
  assign hz.flushCount  = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (small timeout and counter widths
// so the timeout and saturation corners are reachable quickly).
module tb_hazard_ctrl;
  localparam int TMO_W       = 8;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  logic clk;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  hazard_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(
    .TMO_W      (TMO_W),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    hz.rs1AddrD   = 5'd0;
    hz.rs2AddrD   = 5'd0;
    hz.rs1AddrE   = 5'd0;
    hz.rs2AddrE   = 5'd0;
    hz.rdAddrE    = 5'd0;
    hz.ResultSrcE = 2'b00;
    hz.rdAddrM    = 5'd0;
    hz.rdAddrW    = 5'd0;
    hz.RegWriteM  = 1'b0;
    hz.RegWriteW  = 1'b0;
    hz.PCSrcE     = 1'b0;
    hz.MemReqM    = 1'b0;
    hz.MemReadyM  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic br);
    idle();
    hz.ResultSrcE = 2'b01;
    hz.rdAddrE    = rd;
    hz.rs1AddrD   = rs1;
    hz.rs2AddrD   = rs2;
    hz.PCSrcE     = br;
  endtask

  function automatic logic [3:0] stalls();
    return {hz.StallF, hz.StallD, hz.StallE, hz.StallM};
  endfunction

  initial begin
    reset = 1'b0;
    idle();
    hz.RegWriteM = 1'b1;
    hz.rdAddrM   = 5'd7;
    hz.rs1AddrE  = 5'd7;
    hz.PCSrcE    = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_stalls",  32'(stalls()), 32'h0);
    chk("rst_flushD",  32'(hz.FlushD), 32'h1);
    chk("rst_flushE",  32'(hz.FlushE), 32'h1);
    chk("rst_fwdA",    32'(hz.ForwardAE), 32'h0);
    chk("rst_memErr",  32'(hz.memError), 32'h0);
    chk("rst_stallCnt", 32'(hz.stallCycles), 32'h0);
    chk("rst_flushCnt", 32'(hz.flushCount), 32'h0);
    reset = 1'b1;
    idle();

    // Forwarding priority and x0 handling
    tick();
    hz.RegWriteM = 1'b1; hz.RegWriteW = 1'b1;
    hz.rdAddrM = 5'd7; hz.rdAddrW = 5'd7; hz.rs1AddrE = 5'd7; hz.rs2AddrE = 5'd3;
    @(negedge clk);
    chk("fwdA_mem", 32'(hz.ForwardAE), 32'h2);
    chk("fwdB_none", 32'(hz.ForwardBE), 32'h0);
    tick();
    hz.rdAddrM = 5'd0;
    @(negedge clk);
    chk("fwdA_wb", 32'(hz.ForwardAE), 32'h1);
    tick();
    hz.rdAddrM = 5'd0; hz.rdAddrW = 5'd0; hz.rs1AddrE = 5'd0; hz.rs2AddrE = 5'd0;
    @(negedge clk);
    chk("fwdB_x0", 32'(hz.ForwardBE), 32'h0);
    chk("fwdA_x0", 32'(hz.ForwardAE), 32'h0);
    tick();
    hz.rdAddrM = 5'd9; hz.rs2AddrE = 5'd9; hz.RegWriteM = 1'b1;
    hz.rdAddrW = 5'd4; hz.rs1AddrE = 5'd4; hz.RegWriteW = 1'b0;
    @(negedge clk);
    chk("fwdB_mem", 32'(hz.ForwardBE), 32'h2);
    chk("fwdA_wen0", 32'(hz.ForwardAE), 32'h0);
    chk("fwd_nostall", 32'(stalls()), 32'h0);

    // Load-use stall on rs1
    tick();
    load_use(5'd5, 5'd5, 5'd0, 1'b0);
    @(negedge clk);
    chk("lu_stalls", 32'(stalls()), 32'hC);
    chk("lu_flushE", 32'(hz.FlushE), 32'h1);
    chk("lu_flushD", 32'(hz.FlushD), 32'h0);
    tick();
    load_use(5'd0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    chk("lu_cnt", 32'(hz.stallCycles), 32'h1);
    chk("lu_x0_stall", 32'(stalls()), 32'h0);
    chk("lu_x0_flushE", 32'(hz.FlushE), 32'h0);
    tick();
    load_use(5'd6, 5'd1, 5'd6, 1'b0);
    @(negedge clk);
    chk("lu_rs2", 32'(stalls()), 32'hC);

    // Load-use and taken branch together: flush wins
    tick();
    load_use(5'd5, 5'd5, 5'd0, 1'b1);
    @(negedge clk);
    chk("lubr_stalls", 32'(stalls()), 32'h0);
    chk("lubr_flushD", 32'(hz.FlushD), 32'h1);
    chk("lubr_flushE", 32'(hz.FlushE), 32'h1);
    tick();
    idle();
    @(negedge clk);
    chk("lubr_flushCnt", 32'(hz.flushCount), 32'h1);
    chk("lubr_stallCnt", 32'(hz.stallCycles), 32'h2);

    // Memory wait: 3 cycles not ready, then ready, with a branch pending throughout
    for (int i = 0; i < 4; i++) begin
      tick();
      idle();
      hz.MemReqM   = 1'b1;
      hz.MemReadyM = (i == 3);
      hz.PCSrcE    = 1'b1;
      @(negedge clk);
      chk($sformatf("mw_stall%0d", i), 32'(stalls()), 32'hF);
      chk($sformatf("mw_flush%0d", i), 32'({hz.FlushD, hz.FlushE}), 32'h0);
    end
    tick();
    idle();
    hz.PCSrcE = 1'b1;
    @(negedge clk);
    chk("mw_release", 32'(stalls()), 32'h0);
    chk("mw_rel_flush", 32'({hz.FlushD, hz.FlushE}), 32'h3);
    tick();
    idle();
    @(negedge clk);
    chk("mw_stallCnt", 32'(hz.stallCycles), 32'h6);
    chk("mw_flushCnt", 32'(hz.flushCount), 32'h2);

    // Saturation of both counters (4-bit)
    for (int i = 0; i < 11; i++) begin
      tick();
      load_use(5'd3, 5'd3, 5'd0, 1'b0);
    end
    tick();
    idle();
    @(negedge clk);
    chk("sat_stallCnt", 32'(hz.stallCycles), 32'hF);
    for (int i = 0; i < 15; i++) begin
      tick();
      idle();
      hz.PCSrcE = 1'b1;
    end
    tick();
    idle();
    @(negedge clk);
    chk("sat_flushCnt", 32'(hz.flushCount), 32'hF);
    chk("sat_stallHold", 32'(hz.stallCycles), 32'hF);

    // Asynchronous reset in the middle of a wait
    tick();
    idle();
    hz.MemReqM = 1'b1;
    tick();
    @(negedge clk);
    chk("ar_inwait", 32'(stalls()), 32'hF);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_stalls", 32'(stalls()), 32'h0);
    chk("ar_flush", 32'({hz.FlushD, hz.FlushE}), 32'h3);
    chk("ar_stallCnt", 32'(hz.stallCycles), 32'h0);
    chk("ar_flushCnt", 32'(hz.flushCount), 32'h0);
    chk("ar_memErr", 32'(hz.memError), 32'h0);
    idle();
    @(negedge clk);
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("ar_rel_stalls", 32'(stalls()), 32'h0);
    chk("ar_rel_flush", 32'({hz.FlushD, hz.FlushE}), 32'h0);

    // Timeout into the terminal error state
    for (int i = 0; i < 4; i++) begin
      tick();
      idle();
      hz.MemReqM = 1'b1;
      @(negedge clk);
      chk($sformatf("to_stall%0d", i), 32'(stalls()), 32'hF);
      chk($sformatf("to_err%0d", i), 32'(hz.memError), 32'h0);
    end
    tick();
    idle();
    hz.MemReadyM = 1'b1;
    hz.PCSrcE    = 1'b1;
    @(negedge clk);
    chk("to_memErr", 32'(hz.memError), 32'h1);
    chk("to_stallCnt", 32'(hz.stallCycles), 32'h4);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk($sformatf("err_stall%0d", i), 32'(stalls()), 32'hF);
      chk($sformatf("err_flush%0d", i), 32'({hz.FlushD, hz.FlushE}), 32'h0);
    end
    chk("err_memErr", 32'(hz.memError), 32'h1);
    chk("err_stallCnt", 32'(hz.stallCycles), 32'h4);
    chk("err_flushCnt", 32'(hz.flushCount), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
